// File: rtl/prog_job_sequencer.sv
// Host-side job sequencer for the core's arithmetic programs.
// Loads mailbox operands, launches the CPU, waits for halt, reads results.
module prog_job_sequencer #(
  parameter int START_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int ADDR_W         = 8
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_prog,
  input  logic [23:0]       req_operand,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_prog,
  output logic [23:0]       rsp_result,
  output logic              rsp_timeout,
  output logic              rsp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              cpu_start,
  output logic [1:0]        cpu_prog,
  input  logic              cpu_halt,
  output logic              busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_START   = 3'd2;
  localparam logic [2:0] S_WAIT_LO = 3'd3;
  localparam logic [2:0] S_WAIT_HI = 3'd4;
  localparam logic [2:0] S_READ    = 3'd5;
  localparam logic [2:0] S_RESP    = 3'd6;

  localparam int SW = $clog2(START_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] START_LAST = SW'(START_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]    state;
  logic [1:0]    prog;
  logic [23:0]   operand;
  logic [1:0]    idx;
  logic [SW-1:0] scnt;
  logic [TW-1:0] tcnt;

  function automatic logic [ADDR_W-1:0] wr_addr(
    input logic [1:0] p, input logic [1:0] i);
    logic [ADDR_W-1:0] base;
    unique case (p)
      2'd1:    base = ADDR_W'(8);
      2'd2:    base = '0;
      default: base = ADDR_W'(12);
    endcase
    return base + ADDR_W'(i);
  endfunction

  function automatic logic [7:0] wr_data(
    input logic [1:0] p, input logic [1:0] i,
    input logic [23:0] op);
    logic [1:0] k;
    logic [7:0] b;
    // k: byte position counted from op[23:16]
    k = (p == 2'd2) ? i : i + 2'd1;
    unique case (k)
      2'd0:    b = op[23:16];
      2'd1:    b = op[15:8];
      default: b = op[7:0];
    endcase
    return b;
  endfunction

  function automatic logic [ADDR_W-1:0] rd_addr(
    input logic [1:0] p, input logic [1:0] i);
    logic [ADDR_W-1:0] base;
    unique case (p)
      2'd1:    base = ADDR_W'(10);
      2'd2:    base = ADDR_W'(4);
      default: base = ADDR_W'(14);
    endcase
    return base + ADDR_W'(i);
  endfunction

  function automatic logic [1:0] wr_last(input logic [1:0] p);
    return (p == 2'd2) ? 2'd2 : 2'd1;
  endfunction

  function automatic logic [1:0] rd_last(input logic [1:0] p);
    logic [1:0] n;
    unique case (p)
      2'd1:    n = 2'd1;
      2'd2:    n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state       <= S_IDLE;
      prog        <= '0;
      operand     <= '0;
      idx         <= '0;
      scnt        <= '0;
      tcnt        <= '0;
      rsp_prog    <= '0;
      rsp_result  <= '0;
      rsp_timeout <= 1'b0;
      rsp_err     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cpu_start   <= 1'b0;
      cpu_prog    <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (req_valid) begin
          prog        <= req_prog;
          operand     <= req_operand;
          idx         <= '0;
          scnt        <= '0;
          tcnt        <= '0;
          rsp_prog    <= req_prog;
          rsp_timeout <= 1'b0;
          rsp_err     <= 1'b0;
          rsp_result  <= '0;
          if (req_prog == 2'd0) begin
            state      <= S_RESP;
            rsp_err    <= 1'b1;
            rsp_result <= 24'hFFFFFF;
          end else begin
            state     <= S_LOAD;
            mem_we    <= 1'b1;
            mem_addr  <= wr_addr(req_prog, 2'd0);
            mem_wdata <= wr_data(req_prog, 2'd0, req_operand);
          end
        end
        S_LOAD: begin
          if (idx == wr_last(prog)) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_start <= 1'b1;
            cpu_prog  <= prog;
            scnt      <= '0;
            state     <= S_START;
          end else begin
            idx       <= idx + 2'd1;
            mem_addr  <= wr_addr(prog, idx + 2'd1);
            mem_wdata <= wr_data(prog, idx + 2'd1, operand);
          end
        end
        S_START: begin
          if (scnt == START_LAST) begin
            cpu_start <= 1'b0;
            cpu_prog  <= '0;
            tcnt      <= '0;
            state     <= S_WAIT_LO;
          end else begin
            scnt <= scnt + 1'b1;
          end
        end
        S_WAIT_LO: begin
          if (tcnt == TO_LAST) begin
            state       <= S_RESP;
            rsp_timeout <= 1'b1;
            rsp_result  <= 24'hFFFFFF;
          end else begin
            tcnt <= tcnt + 1'b1;
            if (!cpu_halt) state <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          if (cpu_halt) begin
            idx      <= '0;
            mem_addr <= rd_addr(prog, 2'd0);
            state    <= S_READ;
          end else if (tcnt == TO_LAST) begin
            state       <= S_RESP;
            rsp_timeout <= 1'b1;
            rsp_result  <= 24'hFFFFFF;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_READ: begin
          // bytes arrive MSB first, so shift left
          rsp_result <= {rsp_result[15:0], mem_rdata};
          if (idx == rd_last(prog)) begin
            mem_addr <= '0;
            state    <= S_RESP;
          end else begin
            idx      <= idx + 2'd1;
            mem_addr <= rd_addr(prog, idx + 2'd1);
          end
        end
        S_RESP: if (rsp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_job_sequencer.sv
// Randomized bench for prog_job_sequencer with a behavioural CPU/memory
// model and a mailbox-level reference of expected writes and results.
module tb_prog_job_sequencer;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_prog = '0;
  logic [23:0] req_operand = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [1:0]  rsp_prog;
  logic [23:0] rsp_result;
  logic        rsp_timeout;
  logic        rsp_err;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        cpu_start;
  logic [1:0]  cpu_prog;
  logic        cpu_halt = 1'b0;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  prog_job_sequencer #(
    .START_CYCLES(2),
    .TIMEOUT_CYCLES(100),
    .ADDR_W(8)
  ) dut (
    .CLK(CLK), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_prog(req_prog), .req_operand(req_operand),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_prog(rsp_prog), .rsp_result(rsp_result),
    .rsp_timeout(rsp_timeout), .rsp_err(rsp_err),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cpu_start(cpu_start), .cpu_prog(cpu_prog),
    .cpu_halt(cpu_halt), .busy(busy)
  );

  // memory + CPU model
  logic [7:0]  core [256] = '{default: 8'h00};
  logic [15:0] wr_log [$];
  int          start_hi = 0;
  int          rd_cyc = 0;
  int          cpu_ph = 0;
  int          cpu_cnt = 0;
  logic [1:0]  run_prog = '0;
  int          lo_dly = 0;
  int          hi_dly = 1;
  bit          cpu_hang = 1'b0;
  logic [7:0]  cres0 = '0, cres1 = '0, cres2 = '0;

  assign mem_rdata = core[mem_addr];

  always @(posedge CLK) begin
    if (mem_we) begin
      core[mem_addr] <= mem_wdata;
      wr_log.push_back({mem_addr, mem_wdata});
    end
    if (cpu_start) start_hi <= start_hi + 1;
    if (!mem_we && mem_addr != 8'd0) rd_cyc <= rd_cyc + 1;
    if (cpu_start) begin
      cpu_ph   <= 1;
      cpu_cnt  <= 0;
      run_prog <= cpu_prog;
    end else if (cpu_ph == 1) begin
      if (cpu_cnt >= lo_dly) begin
        cpu_halt <= 1'b0;
        cpu_ph   <= 2;
        cpu_cnt  <= 0;
      end else cpu_cnt <= cpu_cnt + 1;
    end else if (cpu_ph == 2 && !cpu_hang) begin
      if (cpu_cnt >= hi_dly) begin
        case (run_prog)
          2'd1: begin core[10] <= cres0; core[11] <= cres1; end
          2'd2: begin
            core[4] <= cres0; core[5] <= cres1; core[6] <= cres2;
          end
          2'd3: core[14] <= cres0;
          default: ;
        endcase
        cpu_halt <= 1'b1;
        cpu_ph   <= 0;
      end else cpu_cnt <= cpu_cnt + 1;
    end
  end

  task automatic run_job(
    input string nm, input logic [1:0] p, input logic [23:0] op,
    input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2,
    input int lo, input int hi, input bit hang, input int hold);
    logic [15:0] ew [$];
    logic [23:0] eres;
    int   nrd, wl0, sh0, rd0, lat, n, wait_n;
    bit   started;
    logic [29:0] snap;
    ew.delete();
    nrd = 0;
    case (p)
      2'd1: begin
        ew.push_back({8'd8, op[15:8]});
        ew.push_back({8'd9, op[7:0]});
        eres = {8'h00, r0, r1}; nrd = 2;
      end
      2'd2: begin
        ew.push_back({8'd0, op[23:16]});
        ew.push_back({8'd1, op[15:8]});
        ew.push_back({8'd2, op[7:0]});
        eres = {r0, r1, r2}; nrd = 3;
      end
      2'd3: begin
        ew.push_back({8'd12, op[15:8]});
        ew.push_back({8'd13, op[7:0]});
        eres = {16'h0000, r0}; nrd = 1;
      end
      default: eres = 24'hFFFFFF;
    endcase
    if (hang && p != 2'd0) begin
      eres = 24'hFFFFFF; nrd = 0;
    end
    lo_dly = lo; hi_dly = hi; cpu_hang = hang;
    cres0 = r0; cres1 = r1; cres2 = r2;
    @(negedge CLK);
    wl0 = wr_log.size(); sh0 = start_hi; rd0 = rd_cyc;
    req_valid = 1'b1; req_prog = p; req_operand = op;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge CLK); n++; end
    checks++;
    if (!req_ready) begin
      errors++;
      $display("FAIL %s accept: req_ready=%b required 1", nm, req_ready);
      req_valid = 1'b0;
      return;
    end
    @(posedge CLK); #1 req_valid = 1'b0;
    lat = 0; started = 0; wait_n = 0;
    do begin
      @(negedge CLK);
      lat++;
      if (cpu_start) started = 1;
      else if (started && !rsp_valid) wait_n++;
    end while (!rsp_valid && lat < 600);
    checks++;
    if (!rsp_valid) begin
      errors++;
      $display("FAIL %s rsp_timeout_wait: rsp_valid=0 required 1", nm);
      return;
    end
    if (p == 2'd0) begin
      checks++;
      if (lat != 1) begin
        errors++;
        $display("FAIL %s err_latency: got %0d required 1", nm, lat);
      end
    end
    if (hang && p != 2'd0) begin
      checks++;
      if (wait_n != 100) begin
        errors++;
        $display("FAIL %s wait_cycles: got %0d required 100", nm, wait_n);
      end
    end
    checks++;
    if (rsp_result !== eres || rsp_prog !== p) begin
      errors++;
      $display("FAIL %s result: got %h/%0d required %h/%0d",
               nm, rsp_result, rsp_prog, eres, p);
    end
    checks++;
    if (rsp_err !== (p == 2'd0) ||
        rsp_timeout !== (hang && p != 2'd0)) begin
      errors++;
      $display("FAIL %s flags: got err=%b to=%b required err=%b to=%b",
               nm, rsp_err, rsp_timeout, p == 2'd0, hang && p != 2'd0);
    end
    checks++;
    if (wr_log.size() - wl0 != ew.size()) begin
      errors++;
      $display("FAIL %s write_count: got %0d required %0d",
               nm, wr_log.size() - wl0, ew.size());
    end else begin
      foreach (ew[i]) begin
        if (wr_log[wl0 + i] !== ew[i]) begin
          errors++;
          $display("FAIL %s write[%0d]: got %h required %h",
                   nm, i, wr_log[wl0 + i], ew[i]);
        end
      end
    end
    checks++;
    if (start_hi - sh0 != ((p == 2'd0) ? 0 : 2)) begin
      errors++;
      $display("FAIL %s start_cycles: got %0d required %0d",
               nm, start_hi - sh0, (p == 2'd0) ? 0 : 2);
    end
    checks++;
    if (rd_cyc - rd0 != nrd) begin
      errors++;
      $display("FAIL %s read_cycles: got %0d required %0d",
               nm, rd_cyc - rd0, nrd);
    end
    snap = {rsp_valid, req_ready, rsp_prog, rsp_result,
            rsp_timeout, rsp_err};
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      checks++;
      if ({rsp_valid, req_ready, rsp_prog, rsp_result,
           rsp_timeout, rsp_err} !== snap || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s hold[%0d]: got v=%b rr=%b res=%h required stable",
                 nm, i, rsp_valid, req_ready, rsp_result);
      end
    end
    rsp_ready = 1'b1;
    @(posedge CLK); #1 rsp_ready = 1'b0;
    @(negedge CLK);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s back_idle: got rr=%b v=%b busy=%b required 1 0 0",
               nm, req_ready, rsp_valid, busy);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(posedge CLK);
    #1 Reset = 1'b0;
    @(negedge CLK);
    checks++;
    if ({req_ready, rsp_valid, cpu_start, mem_we, busy,
         rsp_timeout, rsp_err} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 1000000",
               {req_ready, rsp_valid, cpu_start, mem_we, busy,
                rsp_timeout, rsp_err});
    end
    checks++;
    if ({rsp_result, rsp_prog, cpu_prog, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_data: got res=%h prog=%0d cprog=%0d a=%h d=%h required 0",
               rsp_result, rsp_prog, cpu_prog, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_basic();
    run_job("prog1", 2'd1, 24'h000003, 8'h2A, 8'hAB, 8'h00, 0, 50, 0, 0);
    run_job("prog2", 2'd2, 24'h000103, 8'h00, 8'h55, 8'h55, 0, 20, 0, 0);
  endtask

  task automatic test_stale_halt();
    checks++;
    if (cpu_halt !== 1'b1) begin
      errors++;
      $display("FAIL stale_setup: cpu_halt=%b required 1", cpu_halt);
    end
    run_job("prog3_stale", 2'd3, 24'h00FFFF, 8'hFF, 8'h00, 8'h00, 6, 10, 0, 0);
  endtask

  task automatic test_illegal();
    run_job("illegal", 2'd0, 24'h123456, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0);
  endtask

  task automatic test_timeout();
    run_job("timeout", 2'd1, 24'h00BEEF, 8'h11, 8'h22, 8'h00, 0, 1, 1, 0);
    run_job("after_to", 2'd1, 24'h004242, 8'h5A, 8'hC3, 8'h00, 0, 7, 0, 0);
  endtask

  task automatic test_reset_mid_load();
    int wl0;
    bit bad;
    @(negedge CLK);
    wl0 = wr_log.size();
    req_valid = 1'b1; req_prog = 2'd2; req_operand = 24'hA1B2C3;
    @(posedge CLK); #1 req_valid = 1'b0;
    @(posedge CLK); #1 Reset = 1'b1;
    @(posedge CLK); #1 Reset = 1'b0;
    @(negedge CLK);
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL midload_idle: got rr=%b busy=%b we=%b required 1 0 0",
               req_ready, busy, mem_we);
    end
    repeat (6) @(negedge CLK);
    bad = 0;
    for (int i = wl0; i < wr_log.size(); i++)
      if (wr_log[i][15:8] == 8'd2) bad = 1;
    checks++;
    if (bad || wr_log.size() - wl0 != 2 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL midload_writes: got n=%0d core2=%b v=%b required 2 0 0",
               wr_log.size() - wl0, bad, rsp_valid);
    end
  endtask

  task automatic test_backpressure();
    run_job("bp", 2'd1, 24'h000777, 8'h3C, 8'h96, 8'h00, 1, 5, 0, 10);
  endtask

  task automatic test_random();
    logic [1:0] p;
    for (int k = 0; k < 12; k++) begin
      p = 2'($urandom_range(0, 3));
      run_job("rand", p, 24'($urandom),
              8'($urandom), 8'($urandom), 8'($urandom),
              $urandom_range(0, 4), $urandom_range(1, 20),
              0, $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stale_halt();
    test_illegal();
    test_timeout();
    test_reset_mid_load();
    test_backpressure();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_job_sequencer.md
Name: prog_job_sequencer

Overview:
Host-side controller that sequences the CPU core (TopLevel) through its three arithmetic programs: 1/x (prog 1), 16/8 divide (prog 2) and integer sqrt (prog 3).
- Accepts one job at a time on a valid/ready request port.
- Writes the operand bytes into data memory at the program's fixed mailbox addresses.
- Pulses start, waits for halt, then reads the result bytes back.
- Returns the result on a valid/ready response port.
It owns the data-memory host write/read port and the CPU start/halt handshake.

Parameters:
START_CYCLES, 2, cycles cpu_start is held high per launch (>=1)
TIMEOUT_CYCLES, 1048576, max cycles from start deassertion to halt before the job is aborted
ADDR_W, 8, data-memory address width

Ports:
CLK  in  1  system clock
Reset  in  1  synchronous, active-high reset
req_valid  in  1  job request valid
req_ready  out  1  sequencer can accept a job (high only in IDLE)
req_prog  in  2  program select: 1, 2, 3; 0 is illegal
req_operand  in  24  prog1/prog3: [15:0] operand; prog2: [23:8] dividend, [7:0] divisor
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_prog  out  2  echo of req_prog
rsp_result  out  24  result, zero-extended
rsp_timeout  out  1  job aborted on timeout
rsp_err  out  1  illegal program select
mem_we  out  1  data-memory write enable
mem_addr  out  ADDR_W  data-memory address
mem_wdata  out  8  data-memory write data
mem_rdata  in  8  data-memory read data (combinational from mem_addr)
cpu_start  out  1  CPU start request
cpu_prog  out  2  program select to CPU, valid while cpu_start high
cpu_halt  in  1  CPU done/halt flag
busy  out  1  state != IDLE

Behaviour:
Reset, checked at every clock edge and overriding all else:
- Outputs after reset: state=IDLE; req_ready=1; rsp_valid, cpu_start, mem_we, busy, rsp_timeout, rsp_err=0; rsp_result, rsp_prog, cpu_prog=0.
- Reset mid-job drops the job, with no response and no further memory writes.

Mailbox map, one byte per cycle, in the listed order:
- prog1: write 8=op[15:8], 9=op[7:0]; read 10, 11 into result[15:0].
- prog2: write 0=op[23:16], 1=op[15:8], 2=op[7:0]; read 4, 5, 6 into result[23:0].
- prog3: write 12=op[15:8], 13=op[7:0]; read 14 into result[7:0].
- Unread result bits are 0.

States:
- IDLE: accept when req_valid && req_ready. Latch prog and operand; clear the byte and cycle counters.
  - prog==0: go to RESP with rsp_err=1 and result 0xFFFFFF. No memory or CPU activity.
  - otherwise: go to LOAD.
- LOAD: mem_we=1, one mailbox byte per cycle. After the last byte, go to START.
- START: cpu_start=1 and cpu_prog=prog for exactly START_CYCLES cycles, then go to WAIT_LO.
- WAIT_LO: wait for cpu_halt==0, which rejects a halt left high by the previous job. Then go to WAIT_HI.
- WAIT_HI: wait for cpu_halt==1, then go to READ.
  - Timeout counter: shared by WAIT_LO and WAIT_HI, counts from the first WAIT_LO cycle.
  - When it reaches TIMEOUT_CYCLES: go to RESP with rsp_timeout=1 and result 0xFFFFFF. No readback.
- READ: mem_we=0 and mem_addr = result byte address. mem_rdata is registered at the cycle's clock edge, one byte per cycle, MSB first. After the last byte, go to RESP.
- RESP: rsp_valid=1 with all rsp_* fields stable. Leave when rsp_valid && rsp_ready, going to IDLE; req_ready rises the next cycle.
  - A new request is never accepted in the same cycle as a response handshake.

Outputs and timing:
- mem_we, mem_addr, mem_wdata, cpu_start and cpu_prog are registered.
- mem_addr=0 and mem_wdata=0 whenever the port is not in use.
- Latency from the accept edge to rsp_valid, for a CPU that halts H cycles after WAIT_LO entry with halt already low:
  - prog1: 2 + START_CYCLES + H + 2 + 1
  - prog2: 3 + START_CYCLES + H + 3 + 1
  - prog3: 2 + START_CYCLES + H + 1 + 1
- cpu_halt changes during LOAD, START or READ are ignored.
- rsp_ready held low keeps RESP indefinitely; req_ready stays 0 throughout.

Test Plan:
- prog1, operand 0x0003; CPU model halts after 50 cycles with core[10]=0x2A, core[11]=0xAB -> core[8]=0x00, core[9]=0x03 written; cpu_start high for 2 cycles; rsp_result=0x002AAB, rsp_timeout=0, rsp_err=0.
- prog2, operand 0x000103 (dividend 0x0001, divisor 0x03); model writes 0x00, 0x55, 0x55 to core[4..6] -> writes core[0..2]=00,01,03 in 3 consecutive cycles; rsp_result=0x005555.
- prog3, operand 0xFFFF; model writes core[14]=0xFF; cpu_halt is still high from the previous job at launch -> sequencer waits for halt low before the next halt high; rsp_result=0x0000FF.
- req_prog=0 -> mem_we and cpu_start never assert; rsp_valid one cycle after accept with rsp_err=1 and rsp_result=0xFFFFFF.
- CPU model never halts, TIMEOUT_CYCLES=100 -> rsp_timeout=1 and rsp_result=0xFFFFFF after 100 wait cycles, with no READ cycles. A following prog1 job completes normally.
- Reset asserted in the 2nd LOAD cycle of prog2 -> next cycle IDLE and req_ready=1; core[2] is not written. rsp_ready held low for 10 cycles on a later job -> rsp fields stable and req_ready=0 throughout.
